// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: serialises 1/2/4-byte loads and stores from the load-store buffer
// onto an 8-bit synchronous RAM bus, assembling and extending load data little-endian.
module data_mem_ctrl #(
  parameter int              DAT_W  = 32,
  parameter int              OP_W   = 6,
  parameter logic [OP_W-1:0] OP_LB  = OP_W'(1),
  parameter logic [OP_W-1:0] OP_LH  = OP_W'(2),
  parameter logic [OP_W-1:0] OP_LW  = OP_W'(3),
  parameter logic [OP_W-1:0] OP_LBU = OP_W'(4),
  parameter logic [OP_W-1:0] OP_LHU = OP_W'(5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             lsb_en_i,
  input  logic             lsb_rwen_i,
  input  logic [OP_W-1:0]  lsb_op_i,
  input  logic [2:0]       lsb_len_i,
  input  logic [DAT_W-1:0] lsb_adr_i,
  input  logic [DAT_W-1:0] lsb_dat_i,
  output logic             lsb_en_o,
  output logic [DAT_W-1:0] lsb_dat_o,
  input  logic             br_flag,
  input  logic [7:0]       mem_din,
  output logic [7:0]       mem_dout,
  output logic [DAT_W-1:0] mem_a,
  output logic             mem_wr
);

  localparam int LANE_W = $clog2(DAT_W / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  state_t             r_state;
  logic [2:0]         r_cnt;
  logic [2:0]         r_len;
  logic [OP_W-1:0]    r_op;
  logic [DAT_W-1:0]   r_base;
  logic [DAT_W-1:0]   r_sdat;
  logic [DAT_W-1:0]   r_buf;
  logic               r_lsbEn;
  logic [DAT_W-1:0]   r_lsbDat;
  logic [DAT_W-1:0]   r_memA;
  logic [7:0]         r_memDout;
  logic               r_memWr;

  logic [2:0]         w_cntNext;
  logic [LANE_W-1:0]  w_capIdx;
  logic [LANE_W-1:0]  w_nxtIdx;
  logic [DAT_W-1:0]   w_asm;
  logic [DAT_W-1:0]   w_ext;
  logic [7:0]         w_stByte;
  logic [DAT_W-1:0]   w_nxtAdr;

  // In RD, r_cnt counts edges since the request; the byte arriving now was addressed two edges ago.
  assign w_cntNext = r_cnt + 3'd1;
  assign w_capIdx  = LANE_W'(r_cnt - 3'd1);
  assign w_nxtIdx  = LANE_W'(w_cntNext);
  assign w_stByte  = r_sdat[{w_nxtIdx, 3'b000} +: 8];
  assign w_nxtAdr  = r_base + DAT_W'(w_cntNext);

  always_comb begin
    w_asm = r_buf;
    w_asm[{w_capIdx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    w_ext = w_asm;
    case (r_op)
      OP_LB:   w_ext = {{(DAT_W-8){w_asm[7]}}, w_asm[7:0]};
      OP_LH:   w_ext = {{(DAT_W-16){w_asm[15]}}, w_asm[15:0]};
      OP_LBU:  w_ext = {{(DAT_W-8){1'b0}}, w_asm[7:0]};
      OP_LHU:  w_ext = {{(DAT_W-16){1'b0}}, w_asm[15:0]};
      OP_LW:   w_ext = w_asm;
      default: w_ext = w_asm;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_op      <= '0;
      r_base    <= '0;
      r_sdat    <= '0;
      r_buf     <= '0;
      r_lsbEn   <= 1'b0;
      r_lsbDat  <= '0;
      r_memA    <= '0;
      r_memDout <= '0;
      r_memWr   <= 1'b0;
    end else if (en) begin
      r_lsbEn <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_memWr <= 1'b0;
          // A load arriving together with a flush belongs to the squashed path; stores survive.
          if (lsb_en_i && (lsb_rwen_i || !br_flag)) begin
            r_len  <= lsb_len_i;
            r_op   <= lsb_op_i;
            r_base <= lsb_adr_i;
            r_sdat <= lsb_dat_i;
            r_buf  <= '0;
            r_memA <= lsb_adr_i;
            r_cnt  <= '0;
            if (lsb_rwen_i) begin
              r_state   <= S_WR;
              r_memWr   <= 1'b1;
              r_memDout <= lsb_dat_i[7:0];
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (br_flag) begin
            r_state <= S_IDLE;
          end else begin
            if (w_cntNext < r_len) begin
              r_memA <= w_nxtAdr;
            end
            if (r_cnt != 3'd0) begin
              r_buf <= w_asm;
            end
            if (r_cnt == r_len) begin
              r_lsbDat <= w_ext;
              r_lsbEn  <= 1'b1;
              r_state  <= S_IDLE;
            end
            r_cnt <= w_cntNext;
          end
        end
        S_WR: begin
          if (w_cntNext < r_len) begin
            r_memA    <= w_nxtAdr;
            r_memDout <= w_stByte;
            r_cnt     <= w_cntNext;
          end else begin
            r_memWr <= 1'b0;
            r_lsbEn <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_memWr <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lsb_en_o  = r_lsbEn;
  assign lsb_dat_o = r_lsbDat;
  assign mem_dout  = r_memDout;
  assign mem_a     = r_memA;
  assign mem_wr    = r_memWr;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: drives data_mem_ctrl against a bench-side synchronous byte RAM and
// compares load results, latencies and bus traces with a byte-array reference model.
module tb_data_mem_ctrl;

  localparam int DAT_W = 32;
  localparam int OP_W  = 6;
  localparam logic [OP_W-1:0] LB  = 6'd1;
  localparam logic [OP_W-1:0] LH  = 6'd2;
  localparam logic [OP_W-1:0] LW  = 6'd3;
  localparam logic [OP_W-1:0] LBU = 6'd4;
  localparam logic [OP_W-1:0] LHU = 6'd5;
  localparam logic [OP_W-1:0] SB  = 6'd9;
  localparam logic [OP_W-1:0] SH  = 6'd10;
  localparam logic [OP_W-1:0] SW  = 6'd11;

  logic             clk        = 1'b0;
  logic             rst        = 1'b0;
  logic             en         = 1'b1;
  logic             lsb_en_i   = 1'b0;
  logic             lsb_rwen_i = 1'b0;
  logic [OP_W-1:0]  lsb_op_i   = '0;
  logic [2:0]       lsb_len_i  = '0;
  logic [DAT_W-1:0] lsb_adr_i  = '0;
  logic [DAT_W-1:0] lsb_dat_i  = '0;
  logic             br_flag    = 1'b0;
  logic             lsb_en_o;
  logic [DAT_W-1:0] lsb_dat_o;
  logic [7:0]       mem_din;
  logic [7:0]       mem_dout;
  logic [DAT_W-1:0] mem_a;
  logic             mem_wr;

  logic [7:0]  ram    [0:4095];
  logic [7:0]  refMem [0:4095];
  logic        bdWe   = 1'b0;
  logic [11:0] bdAddr = '0;
  logic [7:0]  bdData = '0;
  logic        tbBusy = 1'b0;

  logic [31:0] trA[$];
  logic        trW[$];
  logic [7:0]  trD[$];
  logic        trE[$];

  int nCompared   = 0;
  int nMismatched = 0;

  data_mem_ctrl #(
    .DAT_W(DAT_W), .OP_W(OP_W),
    .OP_LB(LB), .OP_LH(LH), .OP_LW(LW), .OP_LBU(LBU), .OP_LHU(LHU)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .lsb_en_i(lsb_en_i), .lsb_rwen_i(lsb_rwen_i), .lsb_op_i(lsb_op_i),
    .lsb_len_i(lsb_len_i), .lsb_adr_i(lsb_adr_i), .lsb_dat_i(lsb_dat_i),
    .lsb_en_o(lsb_en_o), .lsb_dat_o(lsb_dat_o), .br_flag(br_flag),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // Synchronous RAM sharing the chip enable, with a backdoor port for preloading.
  always @(posedge clk) begin
    if (bdWe) begin
      ram[bdAddr] <= bdData;
    end else if (en) begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  always @(posedge clk) begin
    if (rst && en && lsb_en_i && tbBusy)
      $error("[TB] protocol violation: request while an access is outstanding");
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got still running, want finished");
    $fatal(1);
  end

  function automatic int opLen(input logic [OP_W-1:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] refLoad(input logic [OP_W-1:0] op, input logic [31:0] adr);
    longint raw;
    logic [31:0] a;
    raw = 0;
    for (int k = 0; k < opLen(op); k++) begin
      a = adr + 32'(k);
      raw += longint'(refMem[a[11:0]]) << (8 * k);
    end
    if (op == LB && raw >= 128) raw -= 256;
    if (op == LH && raw >= 32768) raw -= 65536;
    return 32'(raw);
  endfunction

  task automatic refStore(input logic [OP_W-1:0] op, input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] a;
    for (int k = 0; k < opLen(op); k++) begin
      a = adr + 32'(k);
      refMem[a[11:0]] = dat[8*k +: 8];
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    bdWe   = 1'b1;
    bdAddr = a[11:0];
    bdData = d;
    refMem[a[11:0]] = d;
    @(posedge clk); #1;
    bdWe = 1'b0;
  endtask

  // Issues one request and records the bus after the request edge and after every enabled edge.
  task automatic doAccess(input logic rw, input logic [OP_W-1:0] op, input logic [31:0] adr,
                          input logic [31:0] dat, input int brEdge, input int stallPct,
                          input int maxEdges, output int lat, output logic [31:0] rdat);
    int e;
    int cyc;
    trA.delete(); trW.delete(); trD.delete(); trE.delete();
    lsb_en_i   = 1'b1;
    lsb_rwen_i = rw;
    lsb_op_i   = op;
    lsb_len_i  = 3'(opLen(op));
    lsb_adr_i  = adr;
    lsb_dat_i  = dat;
    br_flag    = (brEdge == 0);
    en         = 1'b1;
    @(posedge clk); #1;
    lsb_en_i  = 1'b0;
    br_flag   = 1'b0;
    lsb_adr_i = $urandom();
    lsb_dat_i = $urandom();
    lsb_op_i  = 6'($urandom());
    lsb_len_i = 3'($urandom_range(1, 4));
    tbBusy    = 1'b1;
    trA.push_back(mem_a); trW.push_back(mem_wr); trD.push_back(mem_dout); trE.push_back(lsb_en_o);
    e = 0; cyc = 0; lat = -1; rdat = '0;
    while (lat < 0 && e < maxEdges && cyc < 20 * maxEdges) begin
      en      = (stallPct == 0) || (int'($urandom_range(0, 99)) >= stallPct);
      br_flag = (brEdge == e + 1);
      @(posedge clk); #1;
      cyc++;
      if (en) begin
        e++;
        trA.push_back(mem_a); trW.push_back(mem_wr); trD.push_back(mem_dout); trE.push_back(lsb_en_o);
        if (lsb_en_o) begin
          lat  = e;
          rdat = lsb_dat_o;
        end
      end
    end
    en = 1'b1; br_flag = 1'b0; tbBusy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nCompared++; if (lsb_en_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_lsb_en_o: got %b want 0", lsb_en_o); end
    nCompared++; if (lsb_dat_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_lsb_dat_o: got %h want 0", lsb_dat_o); end
    nCompared++; if (mem_a !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_mem_a: got %h want 0", mem_a); end
    nCompared++; if (mem_dout !== 8'h0) begin nMismatched++; $display("[TB] FAIL reset_mem_dout: got %h want 0", mem_dout); end
    nCompared++; if (mem_wr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mem_wr: got %b want 0", mem_wr); end
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nCompared++; if ({lsb_en_o, mem_wr, mem_a} !== 34'h0) begin nMismatched++; $display("[TB] FAIL idle_after_reset: got en_o=%b wr=%b a=%h want all 0", lsb_en_o, mem_wr, mem_a); end
  endtask

  task automatic test_load();
    logic [OP_W-1:0] ops  [6];
    logic [31:0]     adrs [6];
    logic [31:0]     exps [6];
    logic [31:0]     rd;
    logic [31:0]     expA;
    int              lat;
    int              n;
    preload(32'h100, 8'h78); preload(32'h101, 8'h56); preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h200, 8'h80); preload(32'h201, 8'h34); preload(32'h202, 8'h92);
    preload(32'hFFE, 8'h01); preload(32'hFFF, 8'h02); preload(32'h000, 8'h03); preload(32'h001, 8'h84);
    ops  = '{LW, LB, LBU, LH, LHU, LW};
    adrs = '{32'h100, 32'h200, 32'h200, 32'h201, 32'h201, 32'hFFFF_FFFE};
    exps = '{32'h1234_5678, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9234, 32'h0000_9234, 32'h8403_0201};
    for (int t = 0; t < 6; t++) begin
      doAccess(1'b0, ops[t], adrs[t], 32'h0, -1, 0, 10, lat, rd);
      n = opLen(ops[t]);
      nCompared++; if (lat !== n + 1) begin nMismatched++; $display("[TB] FAIL load%0d_latency: got %0d want %0d", t, lat, n + 1); end
      nCompared++; if (rd !== exps[t]) begin nMismatched++; $display("[TB] FAIL load%0d_data: got %h want %h", t, rd, exps[t]); end
      for (int k = 0; k < trA.size(); k++) begin
        expA = adrs[t] + 32'((k < n) ? k : n - 1);
        nCompared++; if (trA[k] !== expA || trW[k] !== 1'b0) begin nMismatched++; $display("[TB] FAIL load%0d_bus_edge%0d: got a=%h wr=%b want a=%h wr=0", t, k, trA[k], trW[k], expA); end
      end
    end
  endtask

  task automatic test_store();
    logic [31:0] rd;
    logic [31:0] expA;
    logic [31:0] dat;
    int          lat;
    int          wrCycles;
    dat = 32'hDEAD_BEEF;
    doAccess(1'b1, SW, 32'h3FF, dat, -1, 0, 10, lat, rd);
    refStore(SW, 32'h3FF, dat);
    nCompared++; if (lat !== 4) begin nMismatched++; $display("[TB] FAIL sw_latency: got %0d want 4", lat); end
    wrCycles = 0;
    for (int k = 0; k < trA.size(); k++) begin
      wrCycles += int'(trW[k]);
      expA = 32'h3FF + 32'((k < 4) ? k : 3);
      nCompared++; if (trA[k] !== expA) begin nMismatched++; $display("[TB] FAIL sw_addr_edge%0d: got %h want %h", k, trA[k], expA); end
      if (k < 4) begin
        nCompared++; if (trW[k] !== 1'b1 || trD[k] !== dat[8*k +: 8]) begin nMismatched++; $display("[TB] FAIL sw_byte%0d: got wr=%b d=%h want wr=1 d=%h", k, trW[k], trD[k], dat[8*k +: 8]); end
      end
    end
    nCompared++; if (wrCycles !== 4) begin nMismatched++; $display("[TB] FAIL sw_wr_cycles: got %0d want 4", wrCycles); end
    doAccess(1'b0, LW, 32'h3FF, 32'h0, -1, 0, 10, lat, rd);
    nCompared++; if (rd !== 32'hDEAD_BEEF) begin nMismatched++; $display("[TB] FAIL sw_readback: got %h want deadbeef", rd); end
  endtask

  task automatic test_branch_load();
    logic [31:0] rd;
    int          lat;
    doAccess(1'b0, LW, 32'h100, 32'h0, 2, 0, 8, lat, rd);
    nCompared++; if (lat !== -1) begin nMismatched++; $display("[TB] FAIL br_abort_load: got done at edge %0d want no done", lat); end
    doAccess(1'b1, SB, 32'h10, 32'h1234_565A, -1, 0, 8, lat, rd);
    refStore(SB, 32'h10, 32'h1234_565A);
    nCompared++; if (lat !== 1) begin nMismatched++; $display("[TB] FAIL sb_after_abort_latency: got %0d want 1", lat); end
    nCompared++; if (trA[0] !== 32'h10 || trD[0] !== 8'h5A) begin nMismatched++; $display("[TB] FAIL sb_after_abort_bus: got a=%h d=%h want a=10 d=5a", trA[0], trD[0]); end
    doAccess(1'b0, LBU, 32'h10, 32'h0, -1, 0, 8, lat, rd);
    nCompared++; if (rd !== 32'h5A) begin nMismatched++; $display("[TB] FAIL sb_after_abort_readback: got %h want 5a", rd); end
    doAccess(1'b0, LW, 32'h100, 32'h0, 0, 0, 8, lat, rd);
    nCompared++; if (lat !== -1) begin nMismatched++; $display("[TB] FAIL br_drop_idle_load: got done at edge %0d want no done", lat); end
    doAccess(1'b1, SB, 32'h11, 32'h0000_00A5, 0, 0, 8, lat, rd);
    refStore(SB, 32'h11, 32'h0000_00A5);
    nCompared++; if (lat !== 1) begin nMismatched++; $display("[TB] FAIL br_idle_store_latency: got %0d want 1", lat); end
    doAccess(1'b0, LB, 32'h11, 32'h0, -1, 0, 8, lat, rd);
    nCompared++; if (rd !== 32'hFFFF_FFA5) begin nMismatched++; $display("[TB] FAIL br_idle_store_readback: got %h want ffffffa5", rd); end
  endtask

  task automatic test_branch_store();
    logic [31:0] rd;
    int          lat;
    doAccess(1'b1, SH, 32'h20, 32'h7777_C3D2, 1, 0, 8, lat, rd);
    refStore(SH, 32'h20, 32'h7777_C3D2);
    nCompared++; if (lat !== 2) begin nMismatched++; $display("[TB] FAIL br_store_latency: got %0d want 2", lat); end
    doAccess(1'b0, LHU, 32'h20, 32'h0, -1, 0, 8, lat, rd);
    nCompared++; if (rd !== 32'h0000_C3D2) begin nMismatched++; $display("[TB] FAIL br_store_readback: got %h want 0000c3d2", rd); end
  endtask

  task automatic test_en_stall();
    logic [31:0] rd;
    logic [31:0] expA;
    logic [31:0] dat;
    int          lat;
    doAccess(1'b0, LW, 32'h100, 32'h0, -1, 40, 10, lat, rd);
    nCompared++; if (lat !== 5 || rd !== 32'h1234_5678) begin nMismatched++; $display("[TB] FAIL stall_lw: got lat=%0d d=%h want lat=5 d=12345678", lat, rd); end
    for (int k = 0; k < trA.size(); k++) begin
      expA = 32'h100 + 32'((k < 4) ? k : 3);
      nCompared++; if (trA[k] !== expA) begin nMismatched++; $display("[TB] FAIL stall_lw_addr_edge%0d: got %h want %h", k, trA[k], expA); end
    end
    dat = $urandom();
    doAccess(1'b1, SW, 32'h121, dat, -1, 40, 10, lat, rd);
    refStore(SW, 32'h121, dat);
    nCompared++; if (lat !== 4) begin nMismatched++; $display("[TB] FAIL stall_sw_latency: got %0d want 4", lat); end
    doAccess(1'b0, LW, 32'h121, 32'h0, -1, 40, 10, lat, rd);
    nCompared++; if (rd !== dat) begin nMismatched++; $display("[TB] FAIL stall_sw_readback: got %h want %h", rd, dat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int          lat;
    preload(32'h300, 8'h11); preload(32'h301, 8'h22); preload(32'h302, 8'h33); preload(32'h303, 8'h44);
    lsb_en_i = 1'b1; lsb_rwen_i = 1'b1; lsb_op_i = SW; lsb_len_i = 3'd4;
    lsb_adr_i = 32'h300; lsb_dat_i = 32'hAABB_CCDD;
    @(posedge clk); #1;
    lsb_en_i = 1'b0;
    tbBusy   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    nCompared++; if ({lsb_en_o, lsb_dat_o, mem_a, mem_dout, mem_wr} !== 74'h0) begin nMismatched++; $display("[TB] FAIL reset_mid_outputs: got en_o=%b d=%h a=%h dout=%h wr=%b want all 0", lsb_en_o, lsb_dat_o, mem_a, mem_dout, mem_wr); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      nCompared++; if (mem_wr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mid_wr_hold%0d: got %b want 0", k, mem_wr); end
    end
    rst    = 1'b1;
    tbBusy = 1'b0;
    refMem[12'h300] = 8'hDD;
    doAccess(1'b0, LB, 32'h301, 32'h0, -1, 0, 8, lat, rd);
    nCompared++; if (lat !== 2 || rd !== 32'h22) begin nMismatched++; $display("[TB] FAIL lb_after_reset: got lat=%0d d=%h want lat=2 d=00000022", lat, rd); end
    doAccess(1'b0, LW, 32'h300, 32'h0, -1, 0, 8, lat, rd);
    nCompared++; if (rd !== 32'h4433_22DD) begin nMismatched++; $display("[TB] FAIL partial_store: got %h want 443322dd", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]     rd;
    logic [31:0]     adr;
    logic [31:0]     dat;
    logic [31:0]     expD;
    logic [OP_W-1:0] op;
    logic            rw;
    int              lat;
    int              sel;
    int              expLat;
    int              pulses;
    for (int a = 0; a < 64; a++) preload(32'h500 + 32'(a), 8'($urandom()));
    for (int i = 0; i < 60; i++) begin
      rw  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 4));
      if (rw) op = (sel < 2) ? SB : (sel < 4) ? SH : SW;
      else begin
        case (sel)
          0:       op = LB;
          1:       op = LH;
          2:       op = LW;
          3:       op = LBU;
          default: op = LHU;
        endcase
      end
      adr    = 32'h500 + 32'($urandom_range(0, 60));
      dat    = $urandom();
      expD   = refLoad(op, adr);
      expLat = rw ? opLen(op) : opLen(op) + 1;
      doAccess(rw, op, adr, dat, -1, (i % 2 == 1) ? 25 : 0, 12, lat, rd);
      pulses = 0;
      for (int k = 0; k < trE.size(); k++) pulses += int'(trE[k]);
      nCompared++; if (lat !== expLat) begin nMismatched++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", i, lat, expLat); end
      nCompared++; if (pulses !== 1 || trE[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL rand%0d_pulse: got %0d pulses first=%b want 1 pulse first=0", i, pulses, trE[0]); end
      nCompared++; if (trA[0] !== adr) begin nMismatched++; $display("[TB] FAIL rand%0d_first_addr: got %h want %h", i, trA[0], adr); end
      if (rw) begin
        refStore(op, adr, dat);
      end else begin
        nCompared++; if (rd !== expD) begin nMismatched++; $display("[TB] FAIL rand%0d_load_data: got %h want %h", i, rd, expD); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_branch_load();
    test_branch_store();
    test_en_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
